axis_merger: RTL and testbench

- 2-to-1 AXI-Stream merger; the inverse of the team's 1-to-2 stream selector.
- Arbitrates two slave streams onto one master stream. Used where the two ADC/feedback paths split by the selector rejoin ahead of the shared DAC/processing path.
- Arbitration is burst-based: a grant is held until the source goes idle or BURST_MAX beats have passed.
- The output is registered, with a 1-beat pipeline register and a source tag.

---
 rtl/axis_merger_pkg.sv | 24 ++
 rtl/axis_merger_reg_slice.sv | 53 +++++
 rtl/axis_merger.sv | 196 +++++++++++++++++++
 tb/tb_axis_merger.sv | 393 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_merger_pkg.sv
// Shared types and helpers for the 2-to-1 AXI-Stream merger.
// Build option: AXIS_MERGER_PRIO_EN selects fixed s0-over-s1 priority
// instead of round-robin arbitration.
package axis_merger_pkg;

    // Arbiter states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    // Source index carried alongside each output beat
    typedef logic src_t;

    localparam src_t SRC0 = 1'b0;
    localparam src_t SRC1 = 1'b1;

    // Burst counter width: must be able to hold BURST_MAX itself
    function automatic int unsigned cnt_width(input int unsigned burst_max);
        return $clog2(burst_max + 1);
    endfunction

endpackage

// File: rtl/axis_merger_reg_slice.sv
// Single-entry AXI-Stream output register with tvalid/tready handling.
// in_ready_c is combinational: the slot can take a beat when it is empty
// or when the held beat leaves this cycle.
module axis_reg_slice #(
    parameter int unsigned DW = 17
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] in_data,
    input  logic          in_load,
    output logic          in_ready_c,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready
);

    logic [DW-1:0] data_q;
    logic [DW-1:0] data_d;
    logic          valid_q;
    logic          valid_d;

    // Slot availability seen by the upstream arbiter
    always_comb begin
        in_ready_c = !valid_q || out_ready;
    end

    // Load on a new beat, otherwise empty the slot once it has been taken
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (in_load) begin
            data_d  = in_data;
            valid_d = 1'b1;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    // Output register; reset discards any held beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;

endmodule

// File: rtl/axis_merger.sv
// 2-to-1 AXI-Stream merger with burst-based arbitration and a registered
// output carrying the source index.
// Build option: AXIS_MERGER_PRIO_EN -> fixed priority (s0 wins every
// arbitration); undefined -> round-robin between the two inputs.
// A grant holds until its source drops valid or BURST_MAX beats have been
// taken; the cycle after the last beat of a full burst takes no beat and is
// spent re-arbitrating.
module axis_merger
    import axis_merger_pkg::*;
#(
    parameter int unsigned width     = 16,
    parameter int unsigned BURST_MAX = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [width-1:0] s0_axis_tdata,
    input  logic             s0_axis_tvalid,
    output logic             s0_axis_tready,
    input  logic [width-1:0] s1_axis_tdata,
    input  logic             s1_axis_tvalid,
    output logic             s1_axis_tready,
    output logic [width-1:0] m0_axis_tdata,
    output logic             m0_axis_tvalid,
    input  logic             m0_axis_tready,
    output logic             m0_axis_tsrc
);

    localparam int unsigned   CW      = cnt_width(BURST_MAX);
    localparam int unsigned   SW      = width + 1;
    localparam logic [CW-1:0] CNT_LIM = CW'(BURST_MAX);

    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
`ifndef AXIS_MERGER_PRIO_EN
    src_t          last_grant_q;
    src_t          last_grant_d;
`endif

    logic          acc_c;
    logic          load0;
    logic          load1;
    logic          slice_load;
    logic [SW-1:0] slice_in;
    logic [SW-1:0] slice_out;

    src_t          cur_src;
    logic          cur_valid;
    logic          at_limit;
    logic          beat_ready;
    logic          release_grant;
    logic          grant_req;
    src_t          grant_src;

    // Arbiter: next state, burst count, grant history and input readies
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
`ifndef AXIS_MERGER_PRIO_EN
        last_grant_d   = last_grant_q;
`endif
        s0_axis_tready = 1'b0;
        s1_axis_tready = 1'b0;
        grant_req      = 1'b0;
        grant_src      = SRC0;
        release_grant  = 1'b0;
        cur_src        = (state_q == GRANT1) ? SRC1 : SRC0;
        cur_valid      = (cur_src == SRC1) ? s1_axis_tvalid : s0_axis_tvalid;
        at_limit       = (cnt_q == CNT_LIM);
        beat_ready     = acc_c && !at_limit;

        unique case (state_q)
            IDLE: begin
`ifdef AXIS_MERGER_PRIO_EN
                if (s0_axis_tvalid) begin
                    grant_req = 1'b1;
                    grant_src = SRC0;
                end else if (s1_axis_tvalid) begin
                    grant_req = 1'b1;
                    grant_src = SRC1;
                end
`else
                if (s0_axis_tvalid && s1_axis_tvalid) begin
                    grant_req = 1'b1;
                    grant_src = src_t'(~last_grant_q);
                end else if (s0_axis_tvalid) begin
                    grant_req = 1'b1;
                    grant_src = SRC0;
                end else if (s1_axis_tvalid) begin
                    grant_req = 1'b1;
                    grant_src = SRC1;
                end
`endif
            end

            GRANT0, GRANT1: begin
                if (cur_src == SRC1) begin
                    s1_axis_tready = beat_ready;
                end else begin
                    s0_axis_tready = beat_ready;
                end

                // A valid drop takes precedence over the burst limit
                if (!cur_valid) begin
                    release_grant = 1'b1;
                end else if (at_limit) begin
                    release_grant = 1'b1;
                end else if (beat_ready) begin
                    cnt_d = cnt_q + CW'(1);
                end

                if (release_grant) begin
`ifdef AXIS_MERGER_PRIO_EN
                    if (s0_axis_tvalid) begin
                        grant_req = 1'b1;
                        grant_src = SRC0;
                    end else if (s1_axis_tvalid) begin
                        grant_req = 1'b1;
                        grant_src = SRC1;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
`else
                    if ((cur_src == SRC1) ? s0_axis_tvalid : s1_axis_tvalid) begin
                        grant_req = 1'b1;
                        grant_src = src_t'(~cur_src);
                    end else if (cur_valid) begin
                        // Limit reached, other side idle: keep the grant
                        cnt_d = '0;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
`endif
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        if (grant_req) begin
            state_d      = (grant_src == SRC1) ? GRANT1 : GRANT0;
            cnt_d        = '0;
`ifndef AXIS_MERGER_PRIO_EN
            last_grant_d = grant_src;
`endif
        end
    end

    // Arbiter state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
`ifndef AXIS_MERGER_PRIO_EN
            last_grant_q <= SRC1;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
`ifndef AXIS_MERGER_PRIO_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    // Beat selection into the output register
    always_comb begin
        load0      = s0_axis_tvalid && s0_axis_tready;
        load1      = s1_axis_tvalid && s1_axis_tready;
        slice_load = load0 || load1;
        slice_in   = load1 ? {SRC1, s1_axis_tdata} : {SRC0, s0_axis_tdata};
    end

    axis_reg_slice #(
        .DW (SW)
    ) u_out_slice (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (slice_in),
        .in_load    (slice_load),
        .in_ready_c (acc_c),
        .out_data   (slice_out),
        .out_valid  (m0_axis_tvalid),
        .out_ready  (m0_axis_tready)
    );

    assign m0_axis_tdata = slice_out[width-1:0];
    assign m0_axis_tsrc  = slice_out[width];

endmodule

// File: tb/tb_axis_merger.sv
// Self-checking bench for axis_merger: a BURST_MAX=8 instance for most
// scenarios and a BURST_MAX=1 instance for per-beat regrant.
module tb_axis_merger;

    localparam int unsigned W    = 16;
    localparam int unsigned BM   = 8;
    localparam int unsigned BM_B = 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Instance A (BURST_MAX = 8)
    logic [W-1:0] s0_tdata, s1_tdata, m_tdata;
    logic         s0_tvalid, s1_tvalid, s0_tready, s1_tready;
    logic         m_tvalid, m_tready, m_tsrc;

    // Instance B (BURST_MAX = 1)
    logic [W-1:0] b_s0_tdata, b_s1_tdata, b_m_tdata;
    logic         b_s0_tvalid, b_s1_tvalid, b_s0_tready, b_s1_tready;
    logic         b_m_tvalid, b_m_tready, b_m_tsrc;

    axis_merger #(.width(W), .BURST_MAX(BM)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .s0_axis_tdata(s0_tdata), .s0_axis_tvalid(s0_tvalid), .s0_axis_tready(s0_tready),
        .s1_axis_tdata(s1_tdata), .s1_axis_tvalid(s1_tvalid), .s1_axis_tready(s1_tready),
        .m0_axis_tdata(m_tdata), .m0_axis_tvalid(m_tvalid), .m0_axis_tready(m_tready),
        .m0_axis_tsrc(m_tsrc)
    );

    axis_merger #(.width(W), .BURST_MAX(BM_B)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .s0_axis_tdata(b_s0_tdata), .s0_axis_tvalid(b_s0_tvalid), .s0_axis_tready(b_s0_tready),
        .s1_axis_tdata(b_s1_tdata), .s1_axis_tvalid(b_s1_tvalid), .s1_axis_tready(b_s1_tready),
        .m0_axis_tdata(b_m_tdata), .m0_axis_tvalid(b_m_tvalid), .m0_axis_tready(b_m_tready),
        .m0_axis_tsrc(b_m_tsrc)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: per-source FIFOs of accepted beats, in acceptance order
    logic [W-1:0] exp0[$];
    logic [W-1:0] exp1[$];
    int           idx0, idx1;
    bit           rnd_data;
    int           cyc, rel_cyc;

    // Per-cycle observations
    logic         o_valid, o_src, o_fire, o_r0, o_r1, o_has_exp;
    logic [W-1:0] o_data, o_exp;
    logic         f0, f1;
    int           o_cyc;

    // One clock: sample at negedge, update the model, advance sources after posedge
    task automatic tick();
        @(negedge clk);
        o_valid   = m_tvalid;
        o_data    = m_tdata;
        o_src     = m_tsrc;
        o_r0      = s0_tready;
        o_r1      = s1_tready;
        o_fire    = m_tvalid && m_tready;
        o_cyc     = cyc;
        f0        = s0_tvalid && s0_tready;
        f1        = s1_tvalid && s1_tready;
        o_has_exp = 1'b0;
        o_exp     = '0;
        if (o_fire) begin
            if (o_src == 1'b0 && exp0.size() > 0) begin
                o_exp = exp0.pop_front(); o_has_exp = 1'b1;
            end else if (o_src == 1'b1 && exp1.size() > 0) begin
                o_exp = exp1.pop_front(); o_has_exp = 1'b1;
            end
        end
        if (f0) exp0.push_back(s0_tdata);
        if (f1) exp1.push_back(s1_tdata);
        @(posedge clk);
        #1;
        cyc++;
        if (f0) begin
            idx0++;
            s0_tdata = rnd_data ? W'($urandom) : W'(16'h0001 + idx0);
        end
        if (f1) begin
            idx1++;
            s1_tdata = rnd_data ? W'($urandom) : W'(16'h0100 + idx1);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        s0_tvalid = 1'b0; s1_tvalid = 1'b0; m_tready = 1'b0;
        b_s0_tvalid = 1'b0; b_s1_tvalid = 1'b0; b_m_tready = 1'b0;
        b_s0_tdata = '0; b_s1_tdata = 16'h0200;
        exp0.delete(); exp1.delete();
        idx0 = 0; idx1 = 0; rnd_data = 1'b0;
        s0_tdata = 16'h0001; s1_tdata = 16'h0100;
        tick(); tick();
        rst_n = 1'b1;
        rel_cyc = cyc;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        exp0.delete(); exp1.delete();
        idx0 = 0; idx1 = 0; rnd_data = 1'b0; cyc = 0;
        s0_tdata = 16'h0001; s1_tdata = 16'h0100;
        s0_tvalid = 1'b1; s1_tvalid = 1'b1; m_tready = 1'b1;
        b_s0_tvalid = 1'b0; b_s1_tvalid = 1'b0; b_m_tready = 1'b1;
        b_s0_tdata = '0; b_s1_tdata = 16'h0200;
        tick(); tick();
        checks++;
        if ({o_r0, o_r1, o_valid, o_src, o_data} !== '0 || b_s1_tready !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: r0=%b r1=%b valid=%b src=%b data=%h, required all 0", o_r0, o_r1, o_valid, o_src, o_data);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (o_r0 !== 1'b0 || o_r1 !== 1'b0 || o_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_cycle: r0=%b r1=%b valid=%b, required 0 0 0", o_r0, o_r1, o_valid);
        end
        tick();
        checks++;
        if (o_r0 !== 1'b1 || o_r1 !== 1'b0 || o_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_grant0: r0=%b r1=%b valid=%b, required 1 0 0", o_r0, o_r1, o_valid);
        end
        tick();
        checks++;
        if (o_valid !== 1'b1 || o_data !== 16'h0001 || o_src !== 1'b0) begin
            errors++;
            $display("FAIL reset_first_beat: valid=%b data=%h src=%b, required 1 0001 0", o_valid, o_data, o_src);
        end
        s0_tvalid = 1'b0; s1_tvalid = 1'b0;
    endtask

`ifndef AXIS_MERGER_PRIO_EN
    task automatic test_rr_bursts();
        int k = 0;
        int last = 0;
        do_reset();
        s0_tvalid = 1'b1; s1_tvalid = 1'b1; m_tready = 1'b1;
        for (int n = 0; n < 60; n++) begin
            tick();
            if (o_fire) begin
                checks++;
                if (o_src !== 1'((k / BM) % 2)) begin
                    errors++;
                    $display("FAIL rr_src beat %0d: got %b, required %0d", k, o_src, (k / BM) % 2);
                end
                checks++;
                if (!o_has_exp || o_data !== o_exp) begin
                    errors++;
                    $display("FAIL rr_data beat %0d: got %h, required %h", k, o_data, o_exp);
                end
                checks++;
                if (k == 0 && o_cyc - rel_cyc != 2) begin
                    errors++;
                    $display("FAIL rr_first_latency: got %0d, required 2", o_cyc - rel_cyc);
                end else if (k > 0 && (o_cyc - last - 1) != ((k % BM == 0) ? 1 : 0)) begin
                    errors++;
                    $display("FAIL rr_gap beat %0d: got %0d, required %0d", k, o_cyc - last - 1, (k % BM == 0) ? 1 : 0);
                end
                last = o_cyc;
                k++;
            end
        end
        checks++;
        if (k < 48) begin
            errors++;
            $display("FAIL rr_throughput: got %0d beats, required >= 48", k);
        end
        s0_tvalid = 1'b0; s1_tvalid = 1'b0;
    endtask
`endif

    task automatic test_drop();
        int sent = 0;
        int outs = 0;
        do_reset();
        s0_tvalid = 1'b1; m_tready = 1'b1;
        for (int n = 0; n < 10; n++) begin
            tick();
            if (f0) sent++;
            if (sent == 3) s0_tvalid = 1'b0;
            if (o_fire) begin
                checks++;
                if (o_src !== 1'b0 || !o_has_exp || o_data !== o_exp) begin
                    errors++;
                    $display("FAIL drop_beat %0d: src=%b data=%h, required 0 %h", outs, o_src, o_data, o_exp);
                end
                outs++;
            end
        end
        checks++;
        if (outs != 3 || o_valid !== 1'b0 || o_r0 !== 1'b0 || o_r1 !== 1'b0) begin
            errors++;
            $display("FAIL drop_idle: outs=%0d valid=%b r0=%b r1=%b, required 3 0 0 0", outs, o_valid, o_r0, o_r1);
        end
    endtask

    task automatic test_backpressure();
        int sent = 0;
        int outs = 0;
        int extra = 0;
        logic pv = 1'b0;
        logic pr = 1'b0;
        logic [W-1:0] pd = '0;
        do_reset();
        s1_tvalid = 1'b1; m_tready = 1'b1;
        for (int n = 0; n < 120 && outs < 16; n++) begin
            tick();
            if (f1) sent++;
            if (sent == 16) s1_tvalid = 1'b0;
            if (pv && !pr) begin
                checks++;
                if (o_valid !== 1'b1 || o_data !== pd) begin
                    errors++;
                    $display("FAIL bp_stable: valid=%b data=%h, required 1 %h", o_valid, o_data, pd);
                end
            end
            if (o_fire) begin
                checks++;
                if (o_src !== 1'b1 || o_data !== W'(16'h0100 + outs) || !o_has_exp || o_data !== o_exp) begin
                    errors++;
                    $display("FAIL bp_beat %0d: src=%b data=%h, required 1 %h", outs, o_src, o_data, W'(16'h0100 + outs));
                end
                outs++;
            end
            pv = o_valid; pr = m_tready; pd = o_data;
            m_tready = ~m_tready;
        end
        m_tready = 1'b1;
        for (int n = 0; n < 6; n++) begin
            tick();
            if (o_fire) extra++;
        end
        checks++;
        if (outs != 16 || extra != 0) begin
            errors++;
            $display("FAIL bp_count: got %0d beats plus %0d extra, required 16 plus 0", outs, extra);
        end
    endtask

    task automatic test_burst1();
        int k = 0;
        int last = 0;
        logic fire;
        do_reset();
        b_s1_tvalid = 1'b1; b_m_tready = 1'b1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            fire = b_s1_tvalid && b_s1_tready;
            if (b_m_tvalid) begin
                checks++;
                if (b_m_tsrc !== 1'b1 || b_m_tdata !== W'(16'h0200 + k)) begin
                    errors++;
                    $display("FAIL b1_beat %0d: src=%b data=%h, required 1 %h", k, b_m_tsrc, b_m_tdata, W'(16'h0200 + k));
                end
                if (k > 0) begin
                    checks++;
                    if (n - last != 2) begin
                        errors++;
                        $display("FAIL b1_regrant_gap beat %0d: got %0d, required 2", k, n - last);
                    end
                end
                last = n;
                k++;
            end
            @(posedge clk);
            #1;
            if (fire) b_s1_tdata = b_s1_tdata + W'(1);
        end
        checks++;
        if (k < 15) begin
            errors++;
            $display("FAIL b1_count: got %0d beats, required >= 15", k);
        end
        b_s1_tvalid = 1'b0;
    endtask

`ifdef AXIS_MERGER_PRIO_EN
    task automatic test_prio();
        int found = 0;
        int first_s1 = 0;
        do_reset();
        s0_tvalid = 1'b1; s1_tvalid = 1'b1; m_tready = 1'b1;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (o_fire) begin
                checks++;
                if (o_src !== 1'b0 || !o_has_exp || o_data !== o_exp) begin
                    errors++;
                    $display("FAIL prio_s0_only: src=%b data=%h, required 0 %h", o_src, o_data, o_exp);
                end
            end
        end
        for (int n = 0; n < 20 && found == 0; n++) begin
            tick();
            if (f0) found = 1;
        end
        checks++;
        if (found == 0) begin
            errors++;
            $display("FAIL prio_s0_accept: got no s0 beat, required one within 20 cycles");
        end
        s0_tvalid = 1'b0;
        for (int j = 1; j <= 8; j++) begin
            tick();
            if (o_fire && o_src == 1'b1 && first_s1 == 0) first_s1 = j;
        end
        checks++;
        if (first_s1 != 3) begin
            errors++;
            $display("FAIL prio_s1_latency: first s1 beat at sample %0d, required 3", first_s1);
        end
        s1_tvalid = 1'b0;
    endtask
`endif

    task automatic test_random();
        int sent = 0;
        int outs = 0;
        logic pv = 1'b0;
        logic pr = 1'b0;
        logic [W-1:0] pd = '0;
        do_reset();
        rnd_data = 1'b1;
        s0_tdata = W'($urandom); s1_tdata = W'($urandom);
        for (int n = 0; n < 460; n++) begin
            tick();
            if (f0) sent++;
            if (f1) sent++;
            if (pv && !pr) begin
                checks++;
                if (o_valid !== 1'b1 || o_data !== pd) begin
                    errors++;
                    $display("FAIL rnd_stable: valid=%b data=%h, required 1 %h", o_valid, o_data, pd);
                end
            end
            if (o_fire) begin
                checks++;
                if (!o_has_exp || o_data !== o_exp) begin
                    errors++;
                    $display("FAIL rnd_data src %0d: got %h, required %h", o_src, o_data, o_exp);
                end
                outs++;
            end
            pv = o_valid; pr = m_tready; pd = o_data;
            if (n < 400) begin
                if (!(s0_tvalid && !f0)) s0_tvalid = ($urandom % 4) != 0;
                if (!(s1_tvalid && !f1)) s1_tvalid = ($urandom % 4) != 0;
                m_tready = ($urandom % 3) != 0;
            end else begin
                if (!(s0_tvalid && !f0)) s0_tvalid = 1'b0;
                if (!(s1_tvalid && !f1)) s1_tvalid = 1'b0;
                m_tready = 1'b1;
            end
        end
        checks++;
        if (exp0.size() != 0 || exp1.size() != 0 || o_valid !== 1'b0 || outs != sent) begin
            errors++;
            $display("FAIL rnd_drain: pending %0d/%0d valid=%b outs=%0d sent=%0d, required 0/0 0 equal", exp0.size(), exp1.size(), o_valid, outs, sent);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
`ifndef AXIS_MERGER_PRIO_EN
        test_rr_bursts();
`endif
        test_drop();
        test_backpressure();
        test_burst1();
`ifdef AXIS_MERGER_PRIO_EN
        test_prio();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
